// File: rtl/sseg_scan_sched.sv
// sseg_scan_sched
//
// Time-multiplexing scheduler for a 4-digit common-anode seven-segment
// display sharing one hex-to-seven-segment decoder. A free-running refresh
// counter walks the digit slots 0,1,2,3,0,... and presents the selected
// digit's nibble and decimal point to the decoder while enabling its anode.
// New display data is captured into a one-deep pending set through a
// valid/ready handshake and copied into the active set only on the last
// cycle of a frame, so a frame never mixes old and new digits.
//
// Handshake: a transfer happens on a rising clock edge where upd_valid and
// upd_ready are both 1. upd_ready is simply "pending set empty"; data offered
// while upd_ready is 0 is ignored, not queued, and upd_valid may stay high.
//
// Parameters:
//   REFRESH_BITS  refresh counter width (4..24); slot = 2^(REFRESH_BITS-2)
//                 cycles, frame = 2^REFRESH_BITS cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous reset, active low
//   upd_valid  in   new display data offered
//   upd_ready  out  pending set empty, an update can be taken this cycle
//   hex_in     in   [15:0] digit nibbles, digit i in bits [4i+3:4i], digit 0 rightmost
//   dp_in      in   [3:0] decimal points, active low
//   blank_in   in   [3:0] per-digit blank, 1 keeps that anode off
//   hex_out    out  [3:0] nibble for the shared decoder
//   dp_out     out  decimal point for the shared decoder, active low
//   an         out  [3:0] anode enables, active low, one-hot-low or all-high
//
// Build option:
//   SSEG_SCAN_SCHED_GUARD_EN  when defined, all anodes are held off for the
//                             first 4 cycles of every slot (anti-ghosting dead
//                             time) while hex_out/dp_out already show the new
//                             digit. Needs REFRESH_BITS >= 5.
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.

module sseg_scan_sched #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  hex_out,
    output logic        dp_out,
    output logic [3:0]  an
);

    localparam int SLOT_BITS = REFRESH_BITS - 2;

    logic [REFRESH_BITS-1:0] q;
    logic [15:0]             act_hex;
    logic [3:0]              act_dp;
    logic [3:0]              act_blank;
    logic [15:0]             pnd_hex;
    logic [3:0]              pnd_dp;
    logic [3:0]              pnd_blank;
    logic                    pnd_v;

    logic [1:0]              sel;
    logic                    frame_end;
    logic                    commit;
    logic                    transfer;

    assign sel       = q[REFRESH_BITS-1:REFRESH_BITS-2];
    assign frame_end = &q;
    assign commit    = frame_end & pnd_v;
    // Commit and transfer are mutually exclusive: transfer needs pnd_v == 0.
    assign transfer  = upd_valid & ~pnd_v;
    assign upd_ready = ~pnd_v;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q         <= '0;
            act_hex   <= 16'h0000;
            act_dp    <= 4'b1111;
            act_blank <= 4'b1111;
            pnd_hex   <= 16'h0000;
            pnd_dp    <= 4'b1111;
            pnd_blank <= 4'b1111;
            pnd_v     <= 1'b0;
        end else begin
            q <= q + 1'b1;
            if (commit) begin
                act_hex   <= pnd_hex;
                act_dp    <= pnd_dp;
                act_blank <= pnd_blank;
                pnd_v     <= 1'b0;
            end else if (transfer) begin
                // A transfer on the all-ones cycle itself lands in pending
                // and waits for the next frame boundary.
                pnd_hex   <= hex_in;
                pnd_dp    <= dp_in;
                pnd_blank <= blank_in;
                pnd_v     <= 1'b1;
            end
        end
    end

    always_comb begin
        hex_out = act_hex[3:0];
        dp_out  = act_dp[0];
        case (sel)
            2'd0: begin hex_out = act_hex[3:0];   dp_out = act_dp[0]; end
            2'd1: begin hex_out = act_hex[7:4];   dp_out = act_dp[1]; end
            2'd2: begin hex_out = act_hex[11:8];  dp_out = act_dp[2]; end
            default: begin hex_out = act_hex[15:12]; dp_out = act_dp[3]; end
        endcase
    end

    always_comb begin
        an      = 4'b1111;
        an[sel] = act_blank[sel];
`ifdef SSEG_SCAN_SCHED_GUARD_EN
        // Dead time at the start of each slot lets the previous digit's
        // segment drivers settle before the next anode turns on.
        if (q[SLOT_BITS-1:0] < SLOT_BITS'(4)) begin
            an = 4'b1111;
        end
`endif
    end

endmodule

// File: tb/tb_sseg_scan_sched.sv
// Testbench for sseg_scan_sched. A frame-position model (plain arithmetic on
// a cycle position, plus a one-deep pending queue) predicts every output on
// every cycle; a few hand-computed expectations from the test plan pin the
// model. Build with +define+SSEG_SCAN_SCHED_GUARD_EN for the guard variant.

module tb_sseg_scan_sched;

`ifdef SSEG_SCAN_SCHED_GUARD_EN
    localparam int RB    = 5;
    localparam bit GUARD = 1'b1;
`else
    localparam int RB    = 4;
    localparam bit GUARD = 1'b0;
`endif
    localparam int FRAME = 1 << RB;
    localparam int SLOT  = FRAME / 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] hex_in = 16'h0;
    logic [3:0]  dp_in = 4'hf;
    logic [3:0]  blank_in = 4'hf;
    logic [3:0]  hex_out;
    logic        dp_out;
    logic [3:0]  an;

    always #5 clk = ~clk;

    sseg_scan_sched #(.REFRESH_BITS(RB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .hex_out   (hex_out),
        .dp_out    (dp_out),
        .an        (an)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos is the position of the current cycle within the frame.
    int          m_pos = 0;
    logic [15:0] m_hex = 16'h0;
    logic [3:0]  m_dp = 4'hf;
    logic [3:0]  m_blank = 4'hf;
    logic [23:0] pnd_q[$];          // {blank, dp, hex}, at most one entry
    bit          started = 1'b0;

    always @(posedge clk) begin
        logic [23:0] e;
        started = 1'b1;
        if (!reset_n) begin
            m_pos = 0;
            m_hex = 16'h0;
            m_dp = 4'hf;
            m_blank = 4'hf;
            pnd_q.delete();
        end else begin
            if (m_pos == FRAME - 1 && pnd_q.size() != 0) begin
                e = pnd_q.pop_front();
                {m_blank, m_dp, m_hex} = e;
            end else if (upd_valid && pnd_q.size() == 0) begin
                pnd_q.push_back({blank_in, dp_in, hex_in});
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int d;
        logic [3:0] e_an;
        if (started) begin
            d = m_pos / SLOT;
            e_an = m_blank[d] ? 4'hf : ~(4'b0001 << d);
            if (GUARD && (m_pos % SLOT) < 4) e_an = 4'hf;
            check("model_an", {12'h0, an}, {12'h0, e_an});
            check("model_hex", {12'h0, hex_out}, {12'h0, 4'((m_hex >> (4 * d)) & 16'hf)});
            check("model_dp", {15'h0, dp_out}, {15'h0, m_dp[d]});
            check("model_ready", {15'h0, upd_ready}, {15'h0, pnd_q.size() == 0});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("wait_pos", 16'(m_pos), 16'(p));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (upd_ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", {15'h0, upd_ready}, 16'h1);
    endtask

    task automatic offer(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
        upd_valid = 1'b1;
        hex_in = h;
        dp_in = d;
        blank_in = b;
    endtask

    logic [3:0] s2_an[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] s2_hex[4] = '{4'hF, 4'h2, 4'hD, 4'h4};
    logic       s2_dp[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [3:0] e_an;

        // 1. reset held for 3 cycles
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_an", {12'h0, an}, 16'h000f);
            check("rst_hex", {12'h0, hex_out}, 16'h0);
            check("rst_dp", {15'h0, dp_out}, 16'h1);
            check("rst_ready", {15'h0, upd_ready}, 16'h1);
        end
        reset_n = 1'b1;
        check("rst_pos", 16'(m_pos), 16'h0);

        // 2. scan of 4D2F
        wait_pos(5);
        offer(16'h4D2F, 4'b1011, 4'b0000);
        @(negedge clk);
        upd_valid = 1'b0;
        check("s2_ready_drop", {15'h0, upd_ready}, 16'h0);
        wait_pos(0);
        for (int i = 0; i < FRAME; i++) begin
            e_an = (GUARD && (i % SLOT) < 4) ? 4'hf : s2_an[i / SLOT];
            check("s2_an", {12'h0, an}, {12'h0, e_an});
            check("s2_hex", {12'h0, hex_out}, {12'h0, s2_hex[i / SLOT]});
            check("s2_dp", {15'h0, dp_out}, {15'h0, s2_dp[i / SLOT]});
            if (i == 0) check("s2_ready_back", {15'h0, upd_ready}, 16'h1);
            @(negedge clk);
        end

        // 3. transfer on the all-ones cycle
        wait_pos(FRAME - 1);
        offer(16'h1111, 4'b1111, 4'b0000);
        n = 0;
        do begin
            @(negedge clk);
            upd_valid = 1'b0;
            n++;
            if (n == FRAME - 3) check("s3_old_digit3", {12'h0, hex_out}, 16'h4);
        end while (upd_ready !== 1'b1 && n < 4 * FRAME);
        check("s3_ready_return", 16'(n), 16'(FRAME + 1));
        check("s3_new_digit0", {12'h0, hex_out}, 16'h1);

        // 4. back-pressure: valid held high, data changing every cycle
        for (int i = 0; i < 3 * FRAME; i++) begin
            offer(16'($urandom), 4'($urandom), 4'($urandom));
            @(negedge clk);
        end
        upd_valid = 1'b0;
        wait_ready();

        // 5. blanked digits, then reset with an update pending
        offer(16'($urandom), 4'b1111, 4'b1010);
        @(negedge clk);
        upd_valid = 1'b0;
        wait_ready();
        check("s5_pos0", 16'(m_pos), 16'h0);
        for (int i = 0; i < FRAME; i++) begin
            if ((i / SLOT) == 1 || (i / SLOT) == 3)
                check("s5_blank_an", {12'h0, an}, 16'h000f);
            @(negedge clk);
        end
        offer(16'h8888, 4'b0000, 4'b0000);
        @(negedge clk);
        upd_valid = 1'b0;
        check("s5_pending", {15'h0, upd_ready}, 16'h0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            check("s5_post_rst_an", {12'h0, an}, 16'h000f);
            @(negedge clk);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 40 * FRAME; i++) begin
            upd_valid = ($urandom_range(0, 3) == 0);
            hex_in = 16'($urandom);
            dp_in = 4'($urandom);
            blank_in = 4'($urandom_range(0, 15));
            reset_n = ($urandom_range(0, 150) != 0);
            @(negedge clk);
        end
        upd_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
